// File: rtl/ucie_sb_pkg.sv
// Shared constants for the MBINIT sideband transmit path: LTSM message codes,
// UCIe message-without-data header fields and the header builder.
package ucie_sb_pkg;

    // LTSM message codes offered on i_msg_code
    localparam logic [3:0] MSG_NONE                = 4'd0;
    localparam logic [3:0] MSG_PARAM_REQ           = 4'd1;
    localparam logic [3:0] MSG_PARAM_RESP          = 4'd2;
    localparam logic [3:0] MSG_CAL_DONE_REQ        = 4'd3;
    localparam logic [3:0] MSG_CAL_DONE_RESP       = 4'd4;
    localparam logic [3:0] MSG_REPAIRCLK_INIT_REQ  = 4'd5;
    localparam logic [3:0] MSG_REPAIRCLK_INIT_RESP = 4'd6;

    // MsgCode values: requests and responses share a subcode
    localparam logic [7:0] MSGCODE_MBINIT_REQ  = 8'hA5;
    localparam logic [7:0] MSGCODE_MBINIT_RESP = 8'hAA;

    localparam logic [7:0] SUBCODE_PARAM          = 8'h00;
    localparam logic [7:0] SUBCODE_CAL_DONE       = 8'h02;
    localparam logic [7:0] SUBCODE_REPAIRCLK_INIT = 8'h03;

    localparam logic [15:0] MSGINFO_NONE = 16'h0000;

    // Fixed header fields for a message without data
    localparam logic [4:0] SB_OPCODE_MSG_NO_DATA = 5'b10010;
    localparam logic [2:0] SB_SRCID              = 3'b010;
    localparam logic [2:0] SB_DSTID              = 3'b110;

    // Header field offsets
    localparam int OPCODE_LSB  = 0;
    localparam int MSGCODE_LSB = 14;
    localparam int SRCID_LSB   = 29;
    localparam int SUBCODE_LSB = 32;
    localparam int INFO_LSB    = 40;
    localparam int DSTID_LSB   = 56;
    localparam int CP_BIT      = 62;
    localparam int DP_BIT      = 63;

    localparam int HDR_W = 64;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND0,
        TX_SEND1,
        TX_DONE
    } tx_state_e;

    // Assemble a full header; CP is even parity over every bit below it, DP stays 0
    function automatic logic [HDR_W-1:0] build_header(
        input logic [7:0]  msg_code,
        input logic [7:0]  msg_subcode,
        input logic [15:0] msg_info
    );
        logic [HDR_W-1:0] hdr;
        hdr = '0;
        hdr[OPCODE_LSB +: 5]  = SB_OPCODE_MSG_NO_DATA;
        hdr[MSGCODE_LSB +: 8] = msg_code;
        hdr[SRCID_LSB +: 3]   = SB_SRCID;
        hdr[SUBCODE_LSB +: 8] = msg_subcode;
        hdr[INFO_LSB +: 16]   = msg_info;
        hdr[DSTID_LSB +: 3]   = SB_DSTID;
        hdr[CP_BIT]           = ^hdr[CP_BIT-1:0];
        hdr[DP_BIT]           = 1'b0;
        return hdr;
    endfunction

endpackage

// File: rtl/sb_msg_encode.sv
// Combinational encoder: LTSM message code -> mapped flag and complete
// 64-bit sideband header (including control parity).
module sb_msg_encode
    import ucie_sb_pkg::*;
(
    input  logic [3:0]       i_msg_code,
    output logic             o_mapped,
    output logic [HDR_W-1:0] o_hdr
);

    logic       mapped;
    logic [7:0] msg_code;
    logic [7:0] msg_subcode;

    // Look up MsgCode/MsgSubcode; anything outside the MBINIT set is unmapped
    always_comb begin
        mapped      = 1'b1;
        msg_code    = 8'h00;
        msg_subcode = 8'h00;
        case (i_msg_code)
            MSG_PARAM_REQ: begin
                msg_code    = MSGCODE_MBINIT_REQ;
                msg_subcode = SUBCODE_PARAM;
            end
            MSG_PARAM_RESP: begin
                msg_code    = MSGCODE_MBINIT_RESP;
                msg_subcode = SUBCODE_PARAM;
            end
            MSG_CAL_DONE_REQ: begin
                msg_code    = MSGCODE_MBINIT_REQ;
                msg_subcode = SUBCODE_CAL_DONE;
            end
            MSG_CAL_DONE_RESP: begin
                msg_code    = MSGCODE_MBINIT_RESP;
                msg_subcode = SUBCODE_CAL_DONE;
            end
            MSG_REPAIRCLK_INIT_REQ: begin
                msg_code    = MSGCODE_MBINIT_REQ;
                msg_subcode = SUBCODE_REPAIRCLK_INIT;
            end
            MSG_REPAIRCLK_INIT_RESP: begin
                msg_code    = MSGCODE_MBINIT_RESP;
                msg_subcode = SUBCODE_REPAIRCLK_INIT;
            end
            default: begin
                mapped = 1'b0;
            end
        endcase
    end

    assign o_mapped = mapped;
    assign o_hdr    = build_header(msg_code, msg_subcode, MSGINFO_NONE);

endmodule

// File: rtl/mbinit_sb_msg_tx.sv
// MBINIT sideband transmit bridge: accepts a level-held LTSM message code,
// registers the encoded header and serializes it to the sideband PHY with a
// valid/ready handshake, then pulses o_falling_edge_busy once per send.
module mbinit_sb_msg_tx
    import ucie_sb_pkg::*;
#(
    parameter int DATA_W = 32
)
(
    input  logic              CLK,
    input  logic              rst_n,
    input  logic [3:0]        i_msg_code,
    input  logic              i_msg_valid,
    output logic [DATA_W-1:0] o_sb_data,
    output logic              o_sb_valid,
    input  logic              i_sb_ready,
    output logic              o_busy,
    output logic              o_falling_edge_busy,
    output logic              o_code_err
);

    if ((DATA_W != 32) && (DATA_W != 64)) begin : g_bad_data_w
        $error("mbinit_sb_msg_tx: DATA_W must be 32 or 64");
    end

    localparam int NUM_BEATS = (DATA_W == 32) ? 2 : 1;

    logic             enc_mapped;
    logic [HDR_W-1:0] enc_hdr;

    sb_msg_encode u_encode (
        .i_msg_code (i_msg_code),
        .o_mapped   (enc_mapped),
        .o_hdr      (enc_hdr)
    );

    tx_state_e         state_q, state_d;
    logic              busy_q, busy_d;
    logic              sb_valid_q, sb_valid_d;
    logic [DATA_W-1:0] sb_data_q, sb_data_d;
    logic [DATA_W-1:0] hi_beat_q, hi_beat_d;
    logic [3:0]        code_q, code_d;
    logic              hold_q, hold_d;
    logic              feb_q, feb_d;
    logic              code_err_q, code_err_d;

    logic handshake;
    logic hold_block;
    logic finish;

    // A beat leaves only while we drive valid; ready alone does nothing
    assign handshake  = sb_valid_q && i_sb_ready;
    // The hold only blocks the exact request that was last served
    assign hold_block = hold_q && i_msg_valid && (i_msg_code == code_q);

    // Next-state, header latch and beat mux for the transmit FSM
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        sb_valid_d = sb_valid_q;
        sb_data_d  = sb_data_q;
        hi_beat_d  = hi_beat_q;
        code_d     = code_q;
        hold_d     = hold_q;
        feb_d      = 1'b0;
        code_err_d = 1'b0;
        finish     = 1'b0;

        if (!hold_block) begin
            hold_d = 1'b0;
        end

        case (state_q)
            TX_IDLE: begin
                if (i_msg_valid && !hold_block) begin
                    code_d = i_msg_code;
                    if (enc_mapped) begin
                        busy_d     = 1'b1;
                        sb_valid_d = 1'b1;
                        sb_data_d  = enc_hdr[DATA_W-1:0];
                        hi_beat_d  = enc_hdr[HDR_W-1 -: DATA_W];
                        state_d    = TX_SEND0;
                    end else begin
                        code_err_d = 1'b1;
                        hold_d     = 1'b1;
                    end
                end
            end
            TX_SEND0: begin
                if (handshake) begin
                    if (NUM_BEATS == 2) begin
                        sb_data_d = hi_beat_q;
                        state_d   = TX_SEND1;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            TX_SEND1: begin
                if (handshake) begin
                    finish = 1'b1;
                end
            end
            TX_DONE: begin
                state_d = TX_IDLE;
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        if (finish) begin
            busy_d     = 1'b0;
            sb_valid_d = 1'b0;
            sb_data_d  = '0;
            feb_d      = 1'b1;
            hold_d     = 1'b1;
            state_d    = TX_DONE;
        end
    end

    // FSM and registered outputs; reset abandons any packet without a busy-fall pulse
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q    <= TX_IDLE;
            busy_q     <= 1'b0;
            sb_valid_q <= 1'b0;
            sb_data_q  <= '0;
            hi_beat_q  <= '0;
            code_q     <= MSG_NONE;
            hold_q     <= 1'b0;
            feb_q      <= 1'b0;
            code_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            sb_valid_q <= sb_valid_d;
            sb_data_q  <= sb_data_d;
            hi_beat_q  <= hi_beat_d;
            code_q     <= code_d;
            hold_q     <= hold_d;
            feb_q      <= feb_d;
            code_err_q <= code_err_d;
        end
    end

    assign o_sb_data           = sb_data_q;
    assign o_sb_valid          = sb_valid_q;
    assign o_busy              = busy_q;
    assign o_falling_edge_busy = feb_q;
    assign o_code_err          = code_err_q;

endmodule

// File: tb/tb_mbinit_sb_msg_tx.sv
// Self-checking bench for mbinit_sb_msg_tx: a 32-bit and a 64-bit instance,
// beats checked against a queue of expected header words.
module tb_mbinit_sb_msg_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [3:0]  code32;
    logic        valid32;
    logic        ready32;
    logic [31:0] data32;
    logic        sbv32;
    logic        busy32;
    logic        feb32;
    logic        err32;

    logic [3:0]  code64;
    logic        valid64;
    logic        ready64;
    logic [63:0] data64;
    logic        sbv64;
    logic        busy64;
    logic        feb64;
    logic        err64;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] q32[$];
    logic [63:0] q64[$];
    logic [31:0] mon_exp32;
    logic [63:0] mon_exp64;

    mbinit_sb_msg_tx #(.DATA_W(32)) dut32 (
        .CLK                 (clk),
        .rst_n               (rst_n),
        .i_msg_code          (code32),
        .i_msg_valid         (valid32),
        .o_sb_data           (data32),
        .o_sb_valid          (sbv32),
        .i_sb_ready          (ready32),
        .o_busy              (busy32),
        .o_falling_edge_busy (feb32),
        .o_code_err          (err32)
    );

    mbinit_sb_msg_tx #(.DATA_W(64)) dut64 (
        .CLK                 (clk),
        .rst_n               (rst_n),
        .i_msg_code          (code64),
        .i_msg_valid         (valid64),
        .o_sb_data           (data64),
        .o_sb_valid          (sbv64),
        .i_sb_ready          (ready64),
        .o_busy              (busy64),
        .o_falling_edge_busy (feb64),
        .o_code_err          (err64)
    );

    // Reference header built straight from the field layout
    function automatic logic [63:0] model_hdr(input logic [3:0] code);
        logic [7:0]  mc;
        logic [7:0]  sc;
        logic [63:0] h;
        case (code)
            4'd1:    begin mc = 8'hA5; sc = 8'h00; end
            4'd2:    begin mc = 8'hAA; sc = 8'h00; end
            4'd3:    begin mc = 8'hA5; sc = 8'h02; end
            4'd4:    begin mc = 8'hAA; sc = 8'h02; end
            4'd5:    begin mc = 8'hA5; sc = 8'h03; end
            4'd6:    begin mc = 8'hAA; sc = 8'h03; end
            default: begin mc = 8'h00; sc = 8'h00; end
        endcase
        h        = 64'd0;
        h[4:0]   = 5'b10010;
        h[21:14] = mc;
        h[31:29] = 3'b010;
        h[39:32] = sc;
        h[58:56] = 3'b110;
        h[62]    = ^h[61:0];
        return h;
    endfunction

    task automatic push32(input logic [3:0] code);
        logic [63:0] h;
        h = model_hdr(code);
        q32.push_back(h[31:0]);
        q32.push_back(h[63:32]);
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every beat handshake on either instance pops one expected word
    always @(negedge clk) begin
        if (rst_n && sbv32 && ready32) begin
            vectors++;
            if (q32.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL beat32_unexpected: got %h expected no beat", data32);
            end else begin
                mon_exp32 = q32.pop_front();
                if (data32 !== mon_exp32) begin
                    miscompares++;
                    $display("[TB] FAIL beat32_data: got %h expected %h", data32, mon_exp32);
                end
            end
        end
        if (rst_n && sbv64 && ready64) begin
            vectors++;
            if (q64.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL beat64_unexpected: got %h expected no beat", data64);
            end else begin
                mon_exp64 = q64.pop_front();
                if (data64 !== mon_exp64) begin
                    miscompares++;
                    $display("[TB] FAIL beat64_data: got %h expected %h", data64, mon_exp64);
                end
            end
        end
    end

    task automatic test_reset();
        logic [63:0] h;
        int pulses;
        rst_n = 1'b0;
        valid32 = 1'b0; code32 = 4'd0; ready32 = 1'b1;
        valid64 = 1'b0; code64 = 4'd0; ready64 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({data32, sbv32, busy32, feb32, err32} !== 36'd0) begin
            miscompares++;
            $display("[TB] FAIL reset32_outputs: got %h expected 0", {data32, sbv32, busy32, feb32, err32});
        end
        vectors++;
        if ({data64, sbv64, busy64, feb64, err64} !== 68'd0) begin
            miscompares++;
            $display("[TB] FAIL reset64_outputs: got %h expected 0", {data64, sbv64, busy64, feb64, err64});
        end
        drive_edge();
        rst_n = 1'b1;
        drive_edge();
        code32 = 4'd5; valid32 = 1'b1;
        h = model_hdr(4'd5);
        q32.push_back(h[31:0]);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (sbv32 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_beat0_valid: got %b expected 1", sbv32);
        end
        drive_edge();
        ready32 = 1'b0; rst_n = 1'b0; valid32 = 1'b0;
        @(negedge clk);
        vectors++;
        if (data32 !== h[63:32]) begin
            miscompares++;
            $display("[TB] FAIL reset_send1_data: got %h expected %h", data32, h[63:32]);
        end
        drive_edge();
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({data32, sbv32, busy32, feb32, err32} !== 36'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_packet: got %h expected 0", {data32, sbv32, busy32, feb32, err32});
        end
        ready32 = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (feb32 || busy32 || sbv32) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("[TB] FAIL reset_no_pulse: got %0d activity cycles expected 0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        int extra;
        logic [63:0] h;
        h = model_hdr(4'd3);
        drive_edge();
        ready32 = 1'b1; code32 = 4'd3; valid32 = 1'b1;
        push32(4'd3);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({sbv32, busy32, data32[21:14]} !== {1'b1, 1'b1, 8'hA5}) begin
            miscompares++;
            $display("[TB] FAIL b2b_beat0: got v=%b b=%b code=%h expected v=1 b=1 code=a5", sbv32, busy32, data32[21:14]);
        end
        vectors++;
        if (data32 !== 32'h40294012) begin
            miscompares++;
            $display("[TB] FAIL b2b_beat0_word: got %h expected 40294012", data32);
        end
        @(negedge clk);
        vectors++;
        if ({sbv32, data32[7:0], data32[31], data32[30]} !== {1'b1, 8'h02, 1'b0, h[62]}) begin
            miscompares++;
            $display("[TB] FAIL b2b_beat1: got v=%b sub=%h dp=%b cp=%b expected v=1 sub=02 dp=0 cp=%b",
                     sbv32, data32[7:0], data32[31], data32[30], h[62]);
        end
        vectors++;
        if (data32 !== 32'h06000002) begin
            miscompares++;
            $display("[TB] FAIL b2b_beat1_word: got %h expected 06000002", data32);
        end
        @(negedge clk);
        vectors++;
        if ({feb32, busy32, sbv32} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL b2b_pulse: got feb/busy/valid=%b expected 100", {feb32, busy32, sbv32});
        end
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (feb32 || busy32 || sbv32) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("[TB] FAIL b2b_no_resend: got %0d active cycles expected 0", extra);
        end
        drive_edge();
        valid32 = 1'b0;
        drive_edge();
    endtask

    task automatic test_stall();
        int pulses;
        logic [63:0] h;
        h = model_hdr(4'd4);
        ready32 = 1'b0; code32 = 4'd4; valid32 = 1'b1;
        push32(4'd4);
        @(negedge clk);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({sbv32, busy32, data32} !== {1'b1, 1'b1, h[31:0]}) begin
                miscompares++;
                $display("[TB] FAIL stall_hold_%0d: got v=%b b=%b d=%h expected v=1 b=1 d=%h",
                         i, sbv32, busy32, data32, h[31:0]);
            end
        end
        drive_edge();
        ready32 = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy32, data32} !== {1'b1, h[31:0]}) begin
            miscompares++;
            $display("[TB] FAIL stall_release: got b=%b d=%h expected b=1 d=%h", busy32, data32, h[31:0]);
        end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (feb32) pulses++;
        end
        vectors++;
        if (pulses !== 1) begin
            miscompares++;
            $display("[TB] FAIL stall_pulses: got %0d expected 1", pulses);
        end
        drive_edge();
        valid32 = 1'b0;
        drive_edge();
    endtask

    task automatic test_code_change();
        int pulses;
        ready32 = 1'b1; code32 = 4'd3; valid32 = 1'b1;
        push32(4'd3);
        push32(4'd4);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        drive_edge();
        code32 = 4'd4;
        @(negedge clk);
        vectors++;
        if (feb32 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL change_first_pulse: got %b expected 1", feb32);
        end
        @(negedge clk);
        vectors++;
        if (sbv32 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL change_pulse_gap: got valid %b expected 0", sbv32);
        end
        @(negedge clk);
        vectors++;
        if ({sbv32, data32[21:14]} !== {1'b1, 8'hAA}) begin
            miscompares++;
            $display("[TB] FAIL change_second_beat0: got v=%b code=%h expected v=1 code=aa", sbv32, data32[21:14]);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (feb32) pulses++;
        end
        vectors++;
        if (pulses !== 1) begin
            miscompares++;
            $display("[TB] FAIL change_pulses: got %0d expected 1", pulses);
        end
        drive_edge();
        valid32 = 1'b0;
        drive_edge();
    endtask

    task automatic test_code_err();
        int active;
        bit got;
        code32 = 4'd9; valid32 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({err32, sbv32, busy32} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL err_pulse: got err/valid/busy=%b expected 100", {err32, sbv32, busy32});
        end
        active = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (err32 || sbv32 || busy32) active++;
        end
        vectors++;
        if (active !== 0) begin
            miscompares++;
            $display("[TB] FAIL err_single: got %0d active cycles expected 0", active);
        end
        drive_edge();
        valid32 = 1'b0;
        drive_edge();
        code32 = 4'd1; valid32 = 1'b1;
        push32(4'd1);
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            if (feb32) got = 1'b1;
        end
        vectors++;
        if (got !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL err_recover: got no pulse expected pulse for code 1");
        end
        drive_edge();
        valid32 = 1'b0;
        drive_edge();
    endtask

    task automatic test_all_codes();
        bit got;
        for (int c = 1; c <= 6; c++) begin
            code32 = 4'(c); valid32 = 1'b1;
            push32(4'(c));
            got = 1'b0;
            for (int i = 0; i < 12 && !got; i++) begin
                @(negedge clk);
                if (feb32) got = 1'b1;
            end
            vectors++;
            if (got !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL code_%0d_done: got no pulse expected pulse", c);
            end
            drive_edge();
            valid32 = 1'b0;
            drive_edge();
        end
    endtask

    task automatic test_data64();
        logic [63:0] h;
        bit got;
        h = model_hdr(4'd2);
        ready64 = 1'b1; code64 = 4'd2; valid64 = 1'b1;
        q64.push_back(h);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({sbv64, busy64, data64[21:14], data64[39:32]} !== {1'b1, 1'b1, 8'hAA, 8'h00}) begin
            miscompares++;
            $display("[TB] FAIL w64_beat: got v=%b b=%b code=%h sub=%h expected v=1 b=1 code=aa sub=00",
                     sbv64, busy64, data64[21:14], data64[39:32]);
        end
        @(negedge clk);
        vectors++;
        if ({feb64, sbv64, busy64} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL w64_pulse: got feb/valid/busy=%b expected 100", {feb64, sbv64, busy64});
        end
        drive_edge();
        valid64 = 1'b0;
        drive_edge();
        code64 = 4'd6; valid64 = 1'b1;
        q64.push_back(model_hdr(4'd6));
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (feb64) got = 1'b1;
        end
        vectors++;
        if (got !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL w64_code6_done: got no pulse expected pulse");
        end
        drive_edge();
        valid64 = 1'b0;
        drive_edge();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting mbinit_sb_msg_tx bench");
        test_reset();
        test_back_to_back();
        test_stall();
        test_code_change();
        test_code_err();
        test_all_codes();
        test_data64();
        repeat (2) @(negedge clk);
        vectors++;
        if (q32.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL q32_drained: got %0d beats pending expected 0", q32.size());
        end
        vectors++;
        if (q64.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL q64_drained: got %0d beats pending expected 0", q64.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
